bus_irq_arb: RTL
================

// Module: bus_irq_arb
// PURPOSE
//  Round-robin interrupt arbiter/vector controller above the per-block interrupt registers.
//  Collects NSRC level irq lines, masks them and picks one winner by round robin.
//  Drives a single CPU interrupt; the CPU claims the winner by reading VECTOR and
//  completes it by writing EOI. Sits on the internal bus as three 32-bit registers.
// PARAMETERS
//  ADDR     0   Byte base address (VECTOR=ADDR, EOI=ADDR+4, MASK=ADDR+8), 4-byte aligned
//  NSRC     8   Number of sources, 1..32; IDW=max(1,$clog2(NSRC)) derived localparam
//  HOLDOFF  4   Idle cycles after EOI before re-arbitration, 0..15 (source clear latency)
// PORTS
//  bus_clk      in   1               Clock (bus_in clock/reset fields unused)
//  bus_reset_l  in   1               Async active-low reset
//  bus_in       in   BUS_IN_WIDTH    Internal bus request (addr, re, we, wr_data)
//  bus_out      out  BUS_OUT_WIDTH   Internal bus response (rd_data, rd_ack, wr_ack, irq)
//  irq_in       in   NSRC            Level interrupt requests, synchronous to bus_clk
//  cpu_irq      out  1               Interrupt to CPU, registered
//  cur_id       out  IDW             Granted/in-service source id, debug only
// BEHAVIOUR
//  Reset (async, bus_reset_l=0): state=IDLE, cpu_irq=0, cur_id=0, mask=all 1s (enabled),
//   last=NSRC-1, pend=0, holdoff count=0, rd_ack=wr_ack=0, rd_data=0.
//  Bus: decode on addr[..:2]; rd_ack/wr_ack registered 1 clk after re/we; rd_data 0 unless
//   rd_ack. bus_out irq field = cpu_irq. Unused address bits/offsets: no ack.
//  pend <= irq_in & mask[NSRC-1:0] every clk (1-clk sample).
//  Winner: first set bit of pend scanning last+1, last+2, ... wrapping NSRC-1 -> 0.
//  FSM:
//   IDLE: if count!=0, count--, no arbitration. Else if |pend: cur_id<=winner, ->GRANT.
//   GRANT: cpu_irq=1. VECTOR read (re cycle) -> SERVICE, cpu_irq 0 next clk.
//    If pend[cur_id]==0 (dropped or masked) and no read this clk -> IDLE (withdrawal).
//    Read and withdrawal same clk: read wins (claim), -> SERVICE.
//   SERVICE: cpu_irq=0. EOI write with wr_data[IDW-1:0]==cur_id -> last<=cur_id,
//    count<=HOLDOFF, ->IDLE. EOI with other id: acked, ignored. Mask/drop of cur_id ignored.
//  Latency: irq_in rises at edge k (IDLE, count 0) -> pend edge k+1 -> cpu_irq high edge k+2.
//  VECTOR read data: GRANT -> {1'b1,zeros,cur_id}; SERVICE -> {1'b0,1'b1,zeros,cur_id};
//   IDLE -> 0. Data captured in the re clk, returned with rd_ack. Reading outside GRANT:
//   no state change.
//  EOI read returns 0. MASK: R/W, bits >=NSRC read 0; write effective at next pend sample.
//  EOI outside SERVICE: acked, no effect. Simultaneous EOI and new requests: EOI applies,
//   arbitration waits for HOLDOFF (HOLDOFF=0: arbitrate the clk after return to IDLE).
//  Reset mid-GRANT/SERVICE: everything to reset values; no pending claim is remembered.
// TESTING
//  1 irq_in[3]=1 -> cpu_irq=1 two clks later; read ADDR -> 0x80000003; cpu_irq=0 next clk;
//    write ADDR+4=3 -> IDLE; drop irq_in[3] -> no further cpu_irq.
//  2 irq_in[1],[5] held, repeated read/EOI -> grant order 1,5,1,5 (first grant 1 from reset).
//  3 irq_in[2] pulse 3 clks, no read -> cpu_irq falls within 2 clks of drop; VECTOR read = 0.
//  4 MASK=0xFE, irq_in[0]=1 -> cpu_irq stays 0, MASK reads 0xFE; MASK=0xFF -> cpu_irq 2 clks.
//  5 In SERVICE for id 3, EOI=4 -> stays SERVICE, VECTOR read = 0x40000003; EOI=3 -> IDLE;
//    assert bus_reset_l=0 mid-SERVICE -> cpu_irq=0, MASK=0xFF, VECTOR=0.
//  6 HOLDOFF=4, irq_in[6] held through EOI -> cpu_irq re-asserts exactly HOLDOFF+1 clks after
//    the EOI wr_ack edge; read/EOI ack on same edge as a withdrawal -> claim wins.

Source files
------------

// File: rtl/bus_irq_arb.sv
// bus_irq_arb
//   Round-robin interrupt arbiter and vector controller. Level requests are
//   masked, sampled into a pending register and one winner is granted to the
//   CPU. The CPU claims the winner by reading VECTOR and retires it by
//   writing its id to EOI. After EOI, arbitration pauses for HOLDOFF cycles
//   so the source has time to clear its request line.
//
//   Registers (byte offsets from ADDR):
//     +0  VECTOR  RO  GRANT: {1,0..,id}  SERVICE: {0,1,0..,id}  IDLE: 0
//     +4  EOI     WO  write the in-service id to complete it (reads 0)
//     +8  MASK    RW  per-source enable, bits >= NSRC read 0
//
// Ports
//   bus_clk      clock
//   bus_reset_l  asynchronous active-low reset
//   bus_in       {clk, reset_l, addr[31:0], re, we, wr_data[31:0]}
//                (the clk/reset_l fields are not used)
//   bus_out      {rd_data[31:0], rd_ack, wr_ack, irq}
//   irq_in       level interrupt requests, synchronous to bus_clk
//   cpu_irq      registered interrupt request to the CPU
//   cur_id       granted / in-service source id (debug)
module bus_irq_arb #(
  parameter logic [31:0] ADDR    = 32'h0000_0000,
  parameter int          NSRC    = 8,
  parameter int          HOLDOFF = 4,
  localparam int IDW           = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int BUS_IN_WIDTH  = 68,
  localparam int BUS_OUT_WIDTH = 35
) (
  input  logic                     bus_clk,
  input  logic                     bus_reset_l,
  input  logic [BUS_IN_WIDTH-1:0]  bus_in,
  output logic [BUS_OUT_WIDTH-1:0] bus_out,
  input  logic [NSRC-1:0]          irq_in,
  output logic                     cpu_irq,
  output logic [IDW-1:0]           cur_id
);

  typedef enum logic [1:0] {IDLE, GRANT, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pend;
  logic [IDW-1:0]  last;
  logic [3:0]      count;
  logic [31:0]     rd_data;
  logic            rd_ack;
  logic            wr_ack;

  logic [31:0] bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic        hit_vec;
  logic        hit_eoi;
  logic        hit_mask;
  logic        any_hit;
  logic [31:0] rd_mux;
  logic [IDW-1:0] winner;
  int          scan_pos;
  logic        unused_bits;

  assign bus_addr  = bus_in[65:34];
  assign bus_re    = bus_in[33];
  assign bus_we    = bus_in[32];
  assign bus_wdata = bus_in[31:0];

  // Clock/reset fields of bus_in, byte-lane address bits and high write-data
  // bits carry nothing this block needs.
  assign unused_bits = ^bus_in;

  // Word-address decode; addr[1:0] is ignored, the fourth word is not ours.
  assign hit_vec  = (bus_addr[31:2] == ADDR[31:2]);
  assign hit_eoi  = (bus_addr[31:2] == ADDR[31:2] + 30'd1);
  assign hit_mask = (bus_addr[31:2] == ADDR[31:2] + 30'd2);
  assign any_hit  = hit_vec | hit_eoi | hit_mask;

  always_comb begin
    rd_mux = 32'd0;
    if (hit_vec) begin
      if (state == GRANT)        rd_mux = 32'h8000_0000 | 32'(cur_id);
      else if (state == SERVICE) rd_mux = 32'h4000_0000 | 32'(cur_id);
    end else if (hit_mask) begin
      rd_mux = 32'(mask);
    end
  end

  // Round robin: scan last+1, last+2, ... wrapping. The loop runs from the
  // farthest position down so the nearest set bit overwrites earlier finds;
  // i==NSRC lands on last itself, the lowest priority.
  always_comb begin
    winner   = last;
    scan_pos = 0;
    for (int i = NSRC; i >= 1; i--) begin
      scan_pos = int'(last) + i;
      if (scan_pos >= NSRC) scan_pos = scan_pos - NSRC;
      if (pend[scan_pos[IDW-1:0]]) winner = scan_pos[IDW-1:0];
    end
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state   <= IDLE;
      cpu_irq <= 1'b0;
      cur_id  <= '0;
      mask    <= '1;
      last    <= IDW'(NSRC - 1);
      pend    <= '0;
      count   <= 4'd0;
      rd_data <= 32'd0;
      rd_ack  <= 1'b0;
      wr_ack  <= 1'b0;
    end else begin
      pend    <= irq_in & mask;
      rd_ack  <= bus_re & any_hit;
      wr_ack  <= bus_we & any_hit;
      rd_data <= (bus_re && any_hit) ? rd_mux : 32'd0;
      if (bus_we && hit_mask) mask <= bus_wdata[NSRC-1:0];

      case (state)
        IDLE: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else if (|pend) begin
            cur_id  <= winner;
            cpu_irq <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          // A claim in the same cycle as a withdrawal takes precedence.
          if (bus_re && hit_vec) begin
            cpu_irq <= 1'b0;
            state   <= SERVICE;
          end else if (!pend[cur_id]) begin
            cpu_irq <= 1'b0;
            state   <= IDLE;
          end
        end
        SERVICE: begin
          if (bus_we && hit_eoi && (bus_wdata[IDW-1:0] == cur_id)) begin
            last  <= cur_id;
            count <= 4'(HOLDOFF);
            state <= IDLE;
          end
        end
        default: begin
          cpu_irq <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus_out = {rd_data, rd_ack, wr_ack, cpu_irq};

endmodule
